// File: rtl/timer_pkg.sv
// timer_pkg: shared definitions for the countdown-timer control unit.
//   state_e        FSM states (IDLE, SET, RUN, PAUSE, DONE)
//   F_SEC/MIN/HOUR codes for the edited field driven on o_field
//   MASK_LO/HI     FND digit masks for the low / high display field
//   field_mask()   digit mask belonging to a field code
//   next_field()   SEC -> MIN -> HOUR -> SEC edit rotation
package timer_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SET   = 3'd1,
    S_RUN   = 3'd2,
    S_PAUSE = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  localparam logic [1:0] F_SEC  = 2'd0;
  localparam logic [1:0] F_MIN  = 2'd1;
  localparam logic [1:0] F_HOUR = 2'd2;

  localparam logic [3:0] MASK_LO = 4'b0011;
  localparam logic [3:0] MASK_HI = 4'b1100;

  // Seconds sit on the low digit pair; minutes and hours both use the high pair.
  function automatic logic [3:0] field_mask(input logic [1:0] f);
    return (f == F_SEC) ? MASK_LO : MASK_HI;
  endfunction

  function automatic logic [1:0] next_field(input logic [1:0] f);
    case (f)
      F_SEC:   return F_MIN;
      F_MIN:   return F_HOUR;
      default: return F_SEC;
    endcase
  endfunction

endpackage

// File: rtl/blink_gen.sv
// blink_gen: blink phase generator for the field being edited.
//   Counts clk cycles while en is high; every BLINK_DIV cycles the phase toggles.
//   restart zeroes counter and phase (takes priority over en).
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   en         count enable
//   restart    zero counter and phase on this edge
//   phase      registered blink phase
//   phase_nxt  value phase takes at the next edge (lets the parent register
//              its blink mask in the same cycle as the phase flop)
module blink_gen #(
  parameter int BLINK_DIV = 25_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic restart,
  output logic phase,
  output logic phase_nxt
);

  localparam int CW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(BLINK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          phase_q, phase_d;

  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (restart) begin
      cnt_d   = '0;
      phase_d = 1'b0;
    end else if (en) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d   = '0;
        phase_d = ~phase_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

  assign phase     = phase_q;
  assign phase_nxt = phase_d;

endmodule

// File: rtl/timer_ctrl.sv
// timer_ctrl: control unit for the countdown-timer datapath.
//   Sequences IDLE / SET / RUN / PAUSE / DONE from debounced one-cycle button
//   pulses and drives the datapath strobes plus the FND blink mask.
//   Every output is a flop; an input pulse shows on the outputs one cycle later.
//   Same-cycle button priority: clr > start > mode > up > down.
// Build option:
//   TIMER_ALARM_TO_EN  when defined, DONE returns to IDLE (with o_clear) after
//                      ALARM_CYC cycles without a button; otherwise DONE holds.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   i_btn_*       one-cycle button pulses (mode, start, up, down, clr)
//   i_zero        datapath reports all fields zero
//   o_run_en      datapath count enable (RUN only)
//   o_clear       one-cycle datapath clear
//   o_field       field being edited (0=SEC, 1=MIN, 2=HOUR)
//   o_inc, o_dec  one-cycle +1 / -1 strobes on o_field (SET only)
//   o_blink       per-digit blank mask (1 = blank)
//   o_alarm       high while in DONE
module timer_ctrl
  import timer_pkg::*;
#(
  parameter int BLINK_DIV = 25_000_000,
  parameter int ALARM_CYC = 500_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_btn_mode,
  input  logic       i_btn_start,
  input  logic       i_btn_up,
  input  logic       i_btn_down,
  input  logic       i_btn_clr,
  input  logic       i_zero,
  output logic       o_run_en,
  output logic       o_clear,
  output logic [1:0] o_field,
  output logic       o_inc,
  output logic       o_dec,
  output logic [3:0] o_blink,
  output logic       o_alarm
);

  state_e     state_q, state_d;
  logic [1:0] field_q, field_d;
  logic       run_en_q, run_en_d;
  logic       clear_q, clear_d;
  logic       inc_q, inc_d;
  logic       dec_q, dec_d;
  logic [3:0] blink_q, blink_d;
  logic       alarm_q, alarm_d;

  logic any_btn;
  logic alarm_tmo;
  logic blink_en, blink_restart, blink_phase, blink_phase_nxt;

  assign any_btn = i_btn_mode | i_btn_start | i_btn_up | i_btn_down | i_btn_clr;

`ifdef TIMER_ALARM_TO_EN
  localparam int AW = (ALARM_CYC > 1) ? $clog2(ALARM_CYC) : 1;
  localparam logic [AW-1:0] ALARM_LAST = AW'(ALARM_CYC - 1);

  logic [AW-1:0] alarm_cnt_q, alarm_cnt_d;

  // Counter is 0 on the first DONE cycle and only advances while DONE persists.
  assign alarm_cnt_d = (state_q == S_DONE && state_d == S_DONE) ? alarm_cnt_q + 1'b1 : '0;
  assign alarm_tmo   = (state_q == S_DONE) && (alarm_cnt_q == ALARM_LAST);

  always_ff @(posedge clk) begin
    if (rst) alarm_cnt_q <= '0;
    else     alarm_cnt_q <= alarm_cnt_d;
  end
`else
  logic unused_alarm_cyc;
  assign alarm_tmo        = 1'b0;
  assign unused_alarm_cyc = ALARM_CYC[0];
`endif

  // Next-state and edited-field logic.
  always_comb begin
    state_d = state_q;
    field_d = field_q;
    case (state_q)
      S_IDLE: begin
        if (i_btn_clr) begin
          state_d = S_IDLE;
        end else if (i_btn_start) begin
          if (!i_zero) state_d = S_RUN;
        end else if (i_btn_mode) begin
          state_d = S_SET;
          field_d = F_SEC;
        end
      end
      S_SET: begin
        if (i_btn_clr || i_btn_start) state_d = S_IDLE;
        else if (i_btn_mode)          field_d = next_field(field_q);
      end
      S_RUN: begin
        // Reaching zero outranks any button in the same cycle.
        if (i_zero)           state_d = S_DONE;
        else if (i_btn_clr)   state_d = S_IDLE;
        else if (i_btn_start) state_d = S_PAUSE;
      end
      S_PAUSE: begin
        if (i_btn_clr)                   state_d = S_IDLE;
        else if (i_btn_start && !i_zero) state_d = S_RUN;
      end
      S_DONE: begin
        if (any_btn || alarm_tmo) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode; values land in the output flops together with the state.
  always_comb begin
    clear_d = 1'b0;
    inc_d   = 1'b0;
    dec_d   = 1'b0;
    case (state_q)
      S_IDLE, S_SET, S_PAUSE: clear_d = i_btn_clr;
      S_RUN:                  clear_d = i_btn_clr & ~i_zero;
      S_DONE:                 clear_d = any_btn | alarm_tmo;
      default:                clear_d = 1'b0;
    endcase
    if (state_q == S_SET && !i_btn_clr && !i_btn_start && !i_btn_mode) begin
      inc_d = i_btn_up;
      dec_d = i_btn_down & ~i_btn_up;
    end
    run_en_d = (state_d == S_RUN);
    alarm_d  = (state_d == S_DONE);
    blink_d  = (state_d == S_SET && blink_phase_nxt) ? field_mask(field_d) : 4'b0000;
  end

  // Blink timing restarts whenever the visible field changes or SET is entered.
  assign blink_en      = (state_q == S_SET) && (state_d == S_SET);
  assign blink_restart = (state_d == S_SET) && ((state_q != S_SET) || (field_d != field_q));

  blink_gen #(
    .BLINK_DIV (BLINK_DIV)
  ) u_blink (
    .clk       (clk),
    .rst       (rst),
    .en        (blink_en),
    .restart   (blink_restart),
    .phase     (blink_phase),
    .phase_nxt (blink_phase_nxt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      field_q  <= F_SEC;
      run_en_q <= 1'b0;
      clear_q  <= 1'b0;
      inc_q    <= 1'b0;
      dec_q    <= 1'b0;
      blink_q  <= 4'b0000;
      alarm_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      field_q  <= field_d;
      run_en_q <= run_en_d;
      clear_q  <= clear_d;
      inc_q    <= inc_d;
      dec_q    <= dec_d;
      blink_q  <= blink_d;
      alarm_q  <= alarm_d;
    end
  end

  logic unused_phase;
  assign unused_phase = blink_phase;

  assign o_run_en = run_en_q;
  assign o_clear  = clear_q;
  assign o_field  = field_q;
  assign o_inc    = inc_q;
  assign o_dec    = dec_q;
  assign o_blink  = blink_q;
  assign o_alarm  = alarm_q;

endmodule

// File: tb/tb_timer_ctrl.sv
// tb_timer_ctrl: bench for timer_ctrl (BLINK_DIV=4, ALARM_CYC=10).
//   A behavioural model predicts every output each cycle; directed pins with
//   literal values anchor the model at the interesting points.
//   Define TIMER_ALARM_TO_EN for both bench and RTL to cover the alarm timeout.
module tb_timer_ctrl;

  localparam int BDIV  = 4;
  localparam int ACYC  = 10;
`ifdef TIMER_ALARM_TO_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  localparam logic [4:0] B_CLR   = 5'b10000;
  localparam logic [4:0] B_START = 5'b01000;
  localparam logic [4:0] B_MODE  = 5'b00100;
  localparam logic [4:0] B_UP    = 5'b00010;
  localparam logic [4:0] B_DOWN  = 5'b00001;

  localparam int M_IDLE = 0, M_SET = 1, M_RUN = 2, M_PAUSE = 3, M_DONE = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       b_mode, b_start, b_up, b_down, b_clr, zero;
  logic       o_run_en, o_clear, o_inc, o_dec, o_alarm;
  logic [1:0] o_field;
  logic [3:0] o_blink;

  int n_cmp = 0;
  int n_err = 0;
  int n_inc = 0;
  int n_dec = 0;
  int dec_field = -1;
  bit chk_on = 1'b0;

  always #5 clk = ~clk;

  timer_ctrl #(
    .BLINK_DIV (BDIV),
    .ALARM_CYC (ACYC)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .i_btn_mode  (b_mode),
    .i_btn_start (b_start),
    .i_btn_up    (b_up),
    .i_btn_down  (b_down),
    .i_btn_clr   (b_clr),
    .i_zero      (zero),
    .o_run_en    (o_run_en),
    .o_clear     (o_clear),
    .o_field     (o_field),
    .o_inc       (o_inc),
    .o_dec       (o_dec),
    .o_blink     (o_blink),
    .o_alarm     (o_alarm)
  );

  // ---------------- behavioural model ----------------
  int         ms = M_IDLE;
  int         mf = 0;
  int         set_age = 0;
  int         done_age = 0;
  logic       e_run = 0, e_clear = 0, e_inc = 0, e_dec = 0, e_alarm = 0;
  logic [1:0] e_field = 0;
  logic [3:0] e_blink = 0;

  always @(posedge clk) begin
    int prev_s, prev_f;
    bit any;
    e_clear = 0; e_inc = 0; e_dec = 0;
    if (rst) begin
      ms = M_IDLE; mf = 0; set_age = 0; done_age = 0;
    end else begin
      prev_s = ms; prev_f = mf;
      any = b_clr | b_start | b_mode | b_up | b_down;
      case (ms)
        M_IDLE:
          if (b_clr) e_clear = 1;
          else if (b_start) begin if (!zero) ms = M_RUN; end
          else if (b_mode) begin ms = M_SET; mf = 0; end
        M_SET:
          if (b_clr) begin ms = M_IDLE; e_clear = 1; end
          else if (b_start) ms = M_IDLE;
          else if (b_mode) mf = (mf + 1) % 3;
          else if (b_up) e_inc = 1;
          else if (b_down) e_dec = 1;
        M_RUN:
          if (zero) ms = M_DONE;
          else if (b_clr) begin ms = M_IDLE; e_clear = 1; end
          else if (b_start) ms = M_PAUSE;
        M_PAUSE:
          if (b_clr) begin ms = M_IDLE; e_clear = 1; end
          else if (b_start && !zero) ms = M_RUN;
        default:
          if (any || (TO_EN && done_age == ACYC - 1)) begin ms = M_IDLE; e_clear = 1; end
      endcase
      if (ms == M_SET) set_age = (prev_s != M_SET || mf != prev_f) ? 0 : set_age + 1;
      if (ms == M_DONE) done_age = (prev_s != M_DONE) ? 0 : done_age + 1;
    end
    e_run   = (ms == M_RUN);
    e_alarm = (ms == M_DONE);
    e_field = 2'(mf);
    e_blink = (ms == M_SET && ((set_age / BDIV) % 2) == 1) ? ((mf == 0) ? 4'b0011 : 4'b1100) : 4'b0000;
  end

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // ---------------- per-cycle compare against the model ----------------
  always @(negedge clk) begin
    if (chk_on) begin
      chk("run_en", int'(o_run_en), int'(e_run));
      chk("clear",  int'(o_clear),  int'(e_clear));
      chk("field",  int'(o_field),  int'(e_field));
      chk("inc",    int'(o_inc),    int'(e_inc));
      chk("dec",    int'(o_dec),    int'(e_dec));
      chk("blink",  int'(o_blink),  int'(e_blink));
      chk("alarm",  int'(o_alarm),  int'(e_alarm));
      chk("clear_vs_incdec", int'(o_clear & (o_inc | o_dec)), 0);
      if (o_inc === 1'b1) n_inc++;
      if (o_dec === 1'b1) begin n_dec++; dec_field = int'(o_field); end
    end
  end

  // Apply one button vector for one clock; returns at the next falling edge.
  task automatic cyc(input logic [4:0] b);
    {b_clr, b_start, b_mode, b_up, b_down} = b;
    @(negedge clk);
    {b_clr, b_start, b_mode, b_up, b_down} = 5'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(5'b0);
  endtask

  function automatic int outs();
    return int'({o_run_en, o_clear, o_field, o_inc, o_dec, o_blink, o_alarm});
  endfunction

  initial begin
    rst = 1'b1; zero = 1'b1;
    {b_clr, b_start, b_mode, b_up, b_down} = 5'b0;
    @(negedge clk);
    cyc(5'b0);
    chk_on = 1'b1;
    cyc(5'b0);
    rst = 1'b0;
    chk("reset_outs", outs(), 0);

    // 1: start with zero count is ignored
    cyc(B_START);
    chk("start_on_zero", outs(), 0);

    // 2: edit fields
    cyc(B_MODE);
    chk("set_field_sec", int'(o_field), 0);
    idle(3);
    chk("blink_off_phase", int'(o_blink), 0);
    cyc(5'b0);
    chk("blink_lo_on", int'(o_blink), 4'b0011);
    idle(3);
    chk("blink_lo_hold", int'(o_blink), 4'b0011);
    cyc(5'b0);
    chk("blink_lo_off", int'(o_blink), 0);
    cyc(B_UP); chk("inc1", int'(o_inc), 1);
    cyc(B_UP); chk("inc2", int'(o_inc), 1);
    cyc(B_UP); chk("inc3", int'(o_inc), 1);
    cyc(B_MODE);
    chk("field_min", int'(o_field), 1);
    chk("mode_no_inc", int'(o_inc), 0);
    cyc(B_DOWN);
    chk("dec1", int'(o_dec), 1);
    idle(2);
    cyc(5'b0);
    chk("blink_hi_on", int'(o_blink), 4'b1100);
    chk("inc_total", n_inc, 3);
    chk("dec_total", n_dec, 1);
    chk("dec_field", dec_field, 1);

    // 3: confirm, run, pause, resume
    zero = 1'b0;
    cyc(B_START);
    chk("confirm_idle", {o_run_en, o_blink}, 0);
    chk("confirm_keeps_field", int'(o_field), 1);
    cyc(B_START);
    chk("run_en_on", int'(o_run_en), 1);
    idle(2);
    cyc(B_START);
    chk("pause_run_off", int'(o_run_en), 0);
    cyc(B_UP);
    chk("pause_up_ignored", int'(o_inc), 0);
    zero = 1'b1;
    cyc(B_START);
    chk("pause_start_zero", int'(o_run_en), 0);
    zero = 1'b0;
    cyc(B_START);
    chk("resume", int'(o_run_en), 1);

    // 4: zero beats start in RUN
    zero = 1'b1;
    cyc(B_START);
    chk("done_alarm", int'(o_alarm), 1);
    chk("done_run_off", int'(o_run_en), 0);
    idle(3);
    cyc(B_UP);
    chk("done_exit_clear", int'(o_clear), 1);
    chk("done_exit_alarm", int'(o_alarm), 0);
    cyc(5'b0);
    chk("clear_one_cycle", int'(o_clear), 0);

    // 5: clr in IDLE, then clr+mode+up in SET
    cyc(B_CLR);
    chk("idle_clr", int'(o_clear), 1);
    cyc(B_MODE);
    cyc(B_MODE);
    cyc(B_CLR | B_MODE | B_UP);
    chk("clr_wins_clear", int'(o_clear), 1);
    chk("clr_wins_inc", int'(o_inc), 0);
    chk("clr_wins_field", int'(o_field), 1);
    cyc(B_UP);
    chk("idle_up_ignored", int'(o_inc), 0);

    // reset in the middle of SET while blinking
    cyc(B_MODE);
    idle(5);
    chk("pre_rst_blink", int'(o_blink), 4'b0011);
    rst = 1'b1;
    cyc(5'b0);
    rst = 1'b0;
    chk("mid_reset_outs", outs(), 0);

    // 6: alarm hold / timeout
    zero = 1'b0;
    cyc(B_START);
    zero = 1'b1;
    cyc(5'b0);
    chk("alarm_enter", int'(o_alarm), 1);
`ifdef TIMER_ALARM_TO_EN
    idle(ACYC - 1);
    chk("alarm_last_cycle", int'(o_alarm), 1);
    cyc(5'b0);
    chk("timeout_clear", int'(o_clear), 1);
    chk("timeout_alarm", int'(o_alarm), 0);
`else
    idle(50);
    chk("alarm_hold", int'(o_alarm), 1);
    cyc(B_DOWN);
    chk("hold_exit_clear", int'(o_clear), 1);
`endif
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
